fillscreen: RTL

Screen-fill engine for the 160×120 VGA adapter path. It paints every pixel of the frame with one colour, one pixel per clock. It sits directly upstream of the circle drawing engine in the top-level tasks: the top level runs `fillscreen` to clear the frame, then starts `circle` to draw on top. It uses the same start/done handshake and the same `vga_*` pixel-port bundle as the other drawing engines, so the top level can multiplex plot ports between engines.

---
 rtl/vga_pkg.sv | 11 +
 rtl/fillscreen_xy_scan_counter.sv | 55 +++++
 rtl/fillscreen.sv | 111 +++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA adapter types and frame geometry for the drawing engines.
package vga_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef logic [7:0] x_t;
  typedef logic [6:0] y_t;
  typedef logic [2:0] colour_t;

endpackage

// File: rtl/fillscreen_xy_scan_counter.sv
// Column-major raster scan counter: y runs fastest, x advances when y wraps.
// Reusable by any engine that walks the whole frame one pixel per advance.
module xy_scan_counter
  import vga_pkg::*;
#(
  parameter int W = SCREEN_W,
  parameter int H = SCREEN_H
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic advance,
  output x_t   x,
  output y_t   y,
  output logic last
);

  x_t   x_q, x_d;
  y_t   y_q, y_d;
  logic x_end, y_end;

  assign x_end = (x_q == x_t'(W - 1));
  assign y_end = (y_q == y_t'(H - 1));

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clear) begin
      x_d = '0;
      y_d = '0;
    end else if (advance) begin
      if (y_end) begin
        y_d = '0;
        x_d = x_end ? '0 : x_q + 1'b1;
      end else begin
        y_d = y_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign last = x_end & y_end;

endmodule

// File: rtl/fillscreen.sv
// Screen-fill engine: plots every pixel of the frame once, one per clock.
// FILLSCREEN_STRIPES_EN: colour = x[2:0] (vertical stripes) instead of the latched colour.
module fillscreen
  import vga_pkg::*;
#(
  parameter int SCREEN_W = vga_pkg::SCREEN_W,
  parameter int SCREEN_H = vga_pkg::SCREEN_H
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] colour,
  input  logic       start,
  output logic       done,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

  state_t  state_q, state_d;
  logic    clear, advance, cnt_last;
  x_t      cnt_x;
  y_t      cnt_y;
  colour_t pix_colour;

  logic    done_q, plot_q;
  x_t      x_q;
  y_t      y_q;
  colour_t col_q;

  xy_scan_counter #(.W(SCREEN_W), .H(SCREEN_H)) u_scan (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .advance (advance),
    .x       (cnt_x),
    .y       (cnt_y),
    .last    (cnt_last)
  );

`ifdef FILLSCREEN_STRIPES_EN
  assign pix_colour = cnt_x[2:0];
`else
  colour_t colour_q, colour_d;

  always_comb begin
    colour_d = colour_q;
    if (state_q == S_IDLE && start) colour_d = colour;
  end

  always_ff @(posedge clk) begin
    if (rst) colour_q <= '0;
    else     colour_q <= colour_d;
  end

  assign pix_colour = colour_q;
`endif

  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    advance = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FILL;
          clear   = 1'b1;
        end
      end
      S_FILL: begin
        advance = 1'b1;
        if (cnt_last) state_d = S_DONE;
      end
      S_DONE: begin
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs trail the scan counter by one register stage, so the pixel
  // scanned in a FILL cycle is presented on the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      plot_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == S_DONE);
      plot_q  <= (state_q == S_FILL);
      if (state_q == S_FILL) begin
        x_q   <= cnt_x;
        y_q   <= cnt_y;
        col_q <= pix_colour;
      end
    end
  end

  assign done       = done_q;
  assign vga_plot   = plot_q;
  assign vga_x      = x_q;
  assign vga_y      = y_q;
  assign vga_colour = col_q;

endmodule
